// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding,
// line levels and parity selectors.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel-in / serial-out bundle between
// the TX FIFO side and the framer.
interface uart_tx_frame_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  BUSY;

   modport master (
      output P_DATA,
      output DATA_VALID,
      output PAR_EN,
      output PAR_TYP,
      input  TX_OUT,
      input  BUSY
   );

   modport slave (
      input  P_DATA,
      input  DATA_VALID,
      input  PAR_EN,
      input  PAR_TYP,
      output TX_OUT,
      output BUSY
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// Load/shift register plus bit counter;
// keeps an unshifted copy for parity.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic                  clr,
   input  logic                  shift,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  cur_bit,
   output logic                  nxt_bit,
   output logic                  last_bit,
   output logic [DATA_WIDTH-1:0] word
);

   localparam int CW = $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] shreg;
   logic [CW-1:0]         cnt;

   // Capture word on accept, shift one bit per data cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         shreg <= '0;
         word  <= '0;
         cnt   <= '0;
      end else begin
         if (load) begin
            shreg <= load_data;
            word  <= load_data;
         end else if (shift) begin
            shreg <= shreg >> 1;
         end
         if (clr)
            cnt <= '0;
         else if (shift)
            cnt <= cnt + 1'b1;
      end
   end

   assign cur_bit  = shreg[0];
   assign nxt_bit  = shreg[1];
   assign last_bit = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, data LSB-first,
// optional parity, stop; one bit per CLK.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic           CLK,
   input  logic           RST,
   uart_tx_frame_if.slave bus
);

   tx_state_t state, state_d;

   logic                  tx_d, busy_d;
   logic                  load, clr, shift;
   logic                  cur_bit, nxt_bit, last_bit;
   logic [DATA_WIDTH-1:0] word;
   logic                  par_en_q, par_typ_q;
   logic                  par_bit;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .CLK       (CLK),
      .RST       (RST),
      .load      (load),
      .clr       (clr),
      .shift     (shift),
      .load_data (bus.P_DATA),
      .cur_bit   (cur_bit),
      .nxt_bit   (nxt_bit),
      .last_bit  (last_bit),
      .word      (word)
   );

   assign par_bit = (par_typ_q == ODD) ? ~(^word) : (^word);

   // State, registered line outputs and latched frame options
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         bus.TX_OUT <= IDLE_LEVEL;
         bus.BUSY   <= 1'b0;
         par_en_q   <= 1'b0;
         par_typ_q  <= EVEN;
      end else begin
         state      <= state_d;
         bus.TX_OUT <= tx_d;
         bus.BUSY   <= busy_d;
         if (load) begin
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
         end
      end
   end

   // Next state plus the line level that state will present
   always_comb begin
      state_d = state;
      tx_d    = IDLE_LEVEL;
      busy_d  = 1'b0;
      load    = 1'b0;
      clr     = 1'b0;
      shift   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.DATA_VALID) begin
               load    = 1'b1;
               state_d = START;
               tx_d    = START_BIT;
               busy_d  = 1'b1;
            end
         end
         START: begin
            clr     = 1'b1;
            state_d = DATA;
            tx_d    = cur_bit;
            busy_d  = 1'b1;
         end
         DATA: begin
            busy_d = 1'b1;
            if (last_bit) begin
               state_d = par_en_q ? PARITY : STOP;
               tx_d    = par_en_q ? par_bit : STOP_BIT;
            end else begin
               shift = 1'b1;
               tx_d  = nxt_bit;
            end
         end
         PARITY: begin
            state_d = STOP;
            tx_d    = STOP_BIT;
            busy_d  = 1'b1;
         end
         STOP: begin
            state_d = IDLE;
            tx_d    = IDLE_LEVEL;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frame
// tables plus back-to-back and reset cases.
module tb_uart_tx_frame;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   int total = 0;
   int bad   = 0;
   int rises = 0;
   logic busy_prev = 1'b0;

   uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

   uart_tx_frame #(.DATA_WIDTH(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (bus.BUSY === 1'b1 && busy_prev === 1'b0)
         rises = rises + 1;
      busy_prev = bus.BUSY;
   end

   typedef struct {
      logic [7:0]  data;
      logic        pe;
      logic        pt;
      logic [11:0] frame;
      int          len;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Entered #1 after the acceptance edge (start bit on line)
   task automatic check_frame(input string name,
                              input logic [11:0] frame,
                              input int len);
      for (int i = 0; i < len; i++) begin
         chk($sformatf("%s tx[%0d]", name, i),
             {31'd0, bus.TX_OUT}, {31'd0, frame[i]});
         chk($sformatf("%s busy[%0d]", name, i),
             {31'd0, bus.BUSY}, 32'd1);
         @(posedge CLK); #1;
      end
      chk({name, " idle tx"}, {31'd0, bus.TX_OUT}, 32'd1);
      chk({name, " idle busy"}, {31'd0, bus.BUSY}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b0, {2'b0, 1'b1, 8'hA5, 1'b0}, 10};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};
      vecs[2] = '{8'hA5, 1'b1, 1'b1, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};
      vecs[3] = '{8'h01, 1'b1, 1'b1, {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11};
      vecs[4] = '{8'h01, 1'b1, 1'b0, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11};
      vecs[5] = '{8'h3C, 1'b0, 1'b0, {2'b0, 1'b1, 8'h3C, 1'b0}, 10};
      vecs[6] = '{8'hFF, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0}, 11};
      vecs[7] = '{8'h00, 1'b1, 1'b1, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11};

      bus.P_DATA     = '0;
      bus.DATA_VALID = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;

      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset tx", {31'd0, bus.TX_OUT}, 32'd1);
      chk("reset busy", {31'd0, bus.BUSY}, 32'd0);
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("idle tx", {31'd0, bus.TX_OUT}, 32'd1);
      chk("idle busy", {31'd0, bus.BUSY}, 32'd0);

      for (int v = 0; v < 8; v++) begin
         @(negedge CLK);
         bus.DATA_VALID = 1'b1;
         bus.P_DATA     = vecs[v].data;
         bus.PAR_EN     = vecs[v].pe;
         bus.PAR_TYP    = vecs[v].pt;
         @(posedge CLK); #1;
         bus.DATA_VALID = 1'b0;
         bus.P_DATA     = ~vecs[v].data;
         bus.PAR_EN     = ~vecs[v].pe;
         bus.PAR_TYP    = ~vecs[v].pt;
         check_frame($sformatf("vec%0d", v), vecs[v].frame, vecs[v].len);
      end

      @(negedge CLK);
      rises = 0;
      bus.DATA_VALID = 1'b1;
      bus.P_DATA     = 8'h55;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      @(posedge CLK); #1;
      bus.P_DATA = 8'h0F;
      check_frame("b2b first", {2'b0, 1'b1, 8'h55, 1'b0}, 10);
      @(posedge CLK); #1;
      bus.DATA_VALID = 1'b0;
      bus.P_DATA     = 8'hAA;
      check_frame("b2b second", {2'b0, 1'b1, 8'h0F, 1'b0}, 10);
      @(negedge CLK);
      chk("b2b rising edges", rises, 32'd2);

      @(negedge CLK);
      bus.DATA_VALID = 1'b1;
      bus.P_DATA     = 8'hA5;
      bus.PAR_EN     = 1'b0;
      @(posedge CLK); #1;
      bus.DATA_VALID = 1'b0;
      repeat (4) begin
         @(posedge CLK); #1;
      end
      chk("rst mid bit3", {31'd0, bus.TX_OUT}, 32'd0);
      chk("rst mid busy", {31'd0, bus.BUSY}, 32'd1);
      RST            = 1'b1;
      bus.DATA_VALID = 1'b1;
      bus.P_DATA     = 8'h3C;
      @(posedge CLK); #1;
      chk("rst abandon tx", {31'd0, bus.TX_OUT}, 32'd1);
      chk("rst abandon busy", {31'd0, bus.BUSY}, 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;
      bus.DATA_VALID = 1'b0;
      check_frame("post rst", {2'b0, 1'b1, 8'h3C, 1'b0}, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
